router_mesh_vc: RTL and testbench



---
 rtl/router_mesh_vc.sv | 177 +++++++++++++++++
 tb/tb_router_mesh_vc.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/router_mesh_vc.sv
// XY-routed mesh router with per-class ingress FIFOs and per-(output, class)
// round-robin wormhole arbiters; classes share no state or ready path.
module router_mesh_vc #(
  parameter int DATA_WIDTH    = 32,
  parameter int N_PORTS       = 5,
  parameter int N_CLASSES     = 2,
  parameter int BUFFER_LENGTH = 16,
  parameter int MAX_ROUTERS_X = 4,
  parameter int MAX_ROUTERS_Y = 4,
  parameter int ROUTER_X      = 0,
  parameter int ROUTER_Y      = 0,
  localparam int XW = $clog2(MAX_ROUTERS_X),
  localparam int YW = $clog2(MAX_ROUTERS_Y),
  localparam int CH = N_PORTS * N_CLASSES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CH*DATA_WIDTH-1:0]   in_data,
  input  logic [CH*(XW+YW)-1:0]      in_dest,
  input  logic [CH-1:0]              in_last,
  input  logic [CH-1:0]              in_valid,
  output logic [CH-1:0]              in_ready,
  output logic [CH*DATA_WIDTH-1:0]   out_data,
  output logic [CH*(XW+YW)-1:0]      out_dest,
  output logic [CH-1:0]              out_last,
  output logic [CH-1:0]              out_valid,
  input  logic [CH-1:0]              out_ready
);
  localparam int DW = XW + YW;
  localparam int FW = DATA_WIDTH + DW + 1;
  localparam int AW = $clog2(BUFFER_LENGTH);
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  // FIFO word layout: {data, dest, last}
  logic [FW-1:0] mem [CH][BUFFER_LENGTH];
  logic [AW-1:0] wr_ptr [CH];
  logic [AW-1:0] rd_ptr [CH];
  logic [AW:0]   count  [CH];
  logic          ready_en;
  logic [CH-1:0] push, pop, nonempty, in_pkt;
  logic [FW-1:0] head [CH];
  logic [PW-1:0] route_q [CH];
  logic [PW-1:0] route_head [CH];
  logic [PW-1:0] route_cur [CH];

  logic [CH-1:0] lock_q;
  logic [PW-1:0] owner_q [CH];
  logic [PW-1:0] rr_q    [CH];
  logic [CH-1:0] gnt_vld, gnt_head, gnt_last;
  logic [PW-1:0] gnt_idx [CH];

  function automatic logic [PW-1:0] xy_route(input logic [DW-1:0] dest);
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    x = dest[XW-1:0];
    y = dest[DW-1:XW];
    if (x > XW'(ROUTER_X))      return PW'(3);
    else if (x < XW'(ROUTER_X)) return PW'(4);
    else if (y > YW'(ROUTER_Y)) return PW'(2);
    else if (y < YW'(ROUTER_Y)) return PW'(1);
    else                        return PW'(0);
  endfunction

  always_comb begin
    in_ready = '0;
    push     = '0;
    nonempty = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      nonempty[c]   = (count[c] != '0);
      head[c]       = mem[c][rd_ptr[c]];
      in_ready[c]   = ready_en && (count[c] != (AW+1)'(BUFFER_LENGTH));
      push[c]       = in_valid[c] && in_ready[c];
      route_head[c] = xy_route(head[c][DW:1]);
      route_cur[c]  = in_pkt[c] ? route_q[c] : route_head[c];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < CH; c++) begin
      if (push[c])
        mem[c][wr_ptr[c]] <= {in_data[c*DATA_WIDTH +: DATA_WIDTH], in_dest[c*DW +: DW], in_last[c]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      in_pkt   <= '0;
      for (int unsigned c = 0; c < CH; c++) begin
        wr_ptr[c]  <= '0;
        rd_ptr[c]  <= '0;
        count[c]   <= '0;
        route_q[c] <= '0;
      end
    end else begin
      ready_en <= 1'b1;
      for (int unsigned c = 0; c < CH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c]) begin
          rd_ptr[c] <= rd_ptr[c] + 1'b1;
          in_pkt[c] <= !head[c][0];
          if (!in_pkt[c]) route_q[c] <= route_head[c];
        end
        if (push[c] && !pop[c])      count[c] <= count[c] + 1'b1;
        else if (pop[c] && !push[c]) count[c] <= count[c] - 1'b1;
      end
    end
  end

  always_comb begin
    int unsigned a, i, gch;
    a = 0; i = 0; gch = 0;
    pop       = '0;
    out_valid = '0;
    out_data  = '0;
    out_dest  = '0;
    out_last  = '0;
    gnt_vld   = '0;
    gnt_head  = '0;
    gnt_last  = '0;
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      for (int unsigned k = 0; k < N_CLASSES; k++) begin
        a = o*N_CLASSES + k;
        gnt_idx[a] = '0;
        if (lock_q[a]) begin
          gnt_vld[a] = 1'b1;
          gnt_idx[a] = owner_q[a];
        end else begin
          for (int unsigned off = 0; off < N_PORTS; off++) begin
            i = (int'(rr_q[a]) + off) % N_PORTS;
            if (!gnt_vld[a] && nonempty[i*N_CLASSES+k] && !in_pkt[i*N_CLASSES+k] &&
                route_cur[i*N_CLASSES+k] == PW'(o)) begin
              gnt_vld[a] = 1'b1;
              gnt_idx[a] = PW'(i);
            end
          end
        end
        gch = int'(gnt_idx[a])*N_CLASSES + k;
        if (gnt_vld[a]) begin
          out_valid[a] = nonempty[gch];
          out_data[a*DATA_WIDTH +: DATA_WIDTH] = head[gch][FW-1 -: DATA_WIDTH];
          out_dest[a*DW +: DW] = head[gch][DW:1];
          out_last[a] = head[gch][0];
          gnt_head[a] = !in_pkt[gch];
          gnt_last[a] = head[gch][0];
          pop[gch]    = nonempty[gch] && out_ready[a];
        end
      end
    end
  end

  // A stalled head also locks its arbiter so the grant cannot move while
  // out_valid is held; the lock drops on the handshake of a last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= '0;
      for (int unsigned a = 0; a < CH; a++) begin
        owner_q[a] <= '0;
        rr_q[a]    <= '0;
      end
    end else begin
      for (int unsigned a = 0; a < CH; a++) begin
        if (out_valid[a] && out_ready[a]) begin
          if (gnt_head[a]) rr_q[a] <= PW'((int'(gnt_idx[a]) + 1) % N_PORTS);
          if (gnt_last[a]) lock_q[a] <= 1'b0;
          else begin
            lock_q[a]  <= 1'b1;
            owner_q[a] <= gnt_idx[a];
          end
        end else if (out_valid[a]) begin
          lock_q[a]  <= 1'b1;
          owner_q[a] <= gnt_idx[a];
        end
      end
    end
  end
endmodule

// File: tb/tb_router_mesh_vc.sv
// Directed self-checking bench for router_mesh_vc at node (1,1).
module tb_router_mesh_vc;
  localparam int CH  = 10;
  localparam int DWD = 32;
  localparam logic [3:0] D_LOCAL = 4'b0101;  // {y=1,x=1}
  localparam logic [3:0] D_EAST  = 4'b0111;  // {y=1,x=3}
  localparam logic [3:0] D_WEST  = 4'b0100;  // {y=1,x=0}

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH*DWD-1:0] in_data, out_data;
  logic [CH*4-1:0]   in_dest, out_dest;
  logic [CH-1:0]     in_last, in_valid, in_ready, out_last, out_valid, out_ready;

  router_mesh_vc #(
    .DATA_WIDTH(32), .N_PORTS(5), .N_CLASSES(2), .BUFFER_LENGTH(16),
    .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4), .ROUTER_X(1), .ROUTER_Y(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_dest(out_dest), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] od(input int c);
    return out_data[c*DWD +: DWD];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c, input logic [31:0] d, input logic [3:0] dst, input logic lst);
    in_valid[c]          = 1'b1;
    in_data[c*DWD +: DWD] = d;
    in_dest[c*4 +: 4]    = dst;
    in_last[c]           = lst;
  endtask

  initial begin
    logic [31:0] got_q[$];
    int accepted;
    logic rdy;
    rst_n = 1'b0; in_data = '0; in_dest = '0; in_last = '0; in_valid = '0; out_ready = '1;
    repeat (3) tick;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    tick;
    check("post_rst_in_ready", in_ready, 32'h3FF);

    // single flit local -> east, class 0
    drive(0, 32'hA5, D_EAST, 1'b1);
    tick;
    in_valid = '0;
    check("t1_valid_vec", out_valid, 32'h040);
    check("t1_data", od(6), 32'hA5);
    check("t1_last", out_last[6], 1);
    tick;
    check("t1_drained", out_valid, 0);

    // north and west contend for local: round-robin alternation
    out_ready[0] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      in_valid = '0;
      drive(2, 32'h100 + j, D_LOCAL, 1'b1);
      drive(8, 32'h200 + j, D_LOCAL, 1'b1);
      tick;
    end
    in_valid = '0;
    out_ready[0] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check("t2_valid", out_valid[0], 1);
      check("t2_order", od(0), (j % 2) ? 32'h200 + j/2 : 32'h100 + j/2);
      tick;
    end
    check("t2_idle", out_valid[0], 0);

    // wormhole: 4-flit east packet then 3-flit south packet, never interleaved
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (out_valid[0]) got_q.push_back(od(0));
      in_valid = '0;
      if (cyc < 4) drive(6, 32'hE0 + cyc, D_LOCAL, cyc == 3);
      if (cyc >= 1 && cyc < 4) drive(4, 32'h50 + cyc - 1, D_LOCAL, cyc == 3);
      tick;
    end
    in_valid = '0;
    check("t3_count", got_q.size(), 7);
    for (int j = 0; j < 7; j++)
      check("t3_seq", (j < got_q.size()) ? got_q[j] : 32'hDEADBEEF,
            (j < 4) ? 32'hE0 + j : 32'h50 + j - 4);

    // class 1 unaffected by a stalled class 0 on the same output
    out_ready[0] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      drive(0, 32'h400 + j, D_LOCAL, 1'b1);
      tick;
    end
    in_valid = '0;
    drive(3, 32'hC1, D_LOCAL, 1'b1);
    tick;
    in_valid = '0;
    check("t4_c1_valid", out_valid[1], 1);
    check("t4_c1_data", od(1), 32'hC1);
    check("t4_c0_held_valid", out_valid[0], 1);
    check("t4_c0_held_data", od(0), 32'h400);
    tick;
    check("t4_c1_done", out_valid[1], 0);
    out_ready[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      check("t4_c0_drain", od(0), 32'h400 + j);
      tick;
    end
    check("t4_c0_idle", out_valid[0], 0);

    // FIFO full: 17 offered, 16 accepted, drained in order
    out_ready[0] = 1'b0;
    accepted = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid = '0;
      if (accepted < 17) drive(0, 32'h600 + accepted, D_LOCAL, 1'b1);
      rdy = in_ready[0];
      tick;
      if (in_valid[0] && rdy) accepted++;
    end
    in_valid = '0;
    check("t5_accepted", accepted, 16);
    check("t5_full_ready", in_ready[0], 0);
    out_ready[0] = 1'b1;
    for (int j = 0; j < 16; j++) begin
      check("t5_drain_valid", out_valid[0], 1);
      check("t5_drain_data", od(0), 32'h600 + j);
      tick;
    end
    check("t5_empty", out_valid[0], 0);
    check("t5_ready_back", in_ready[0], 1);

    // reset in the middle of a 4-flit packet
    out_ready[6] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      drive(0, 32'h700 + j, D_EAST, 1'b0);
      tick;
    end
    in_valid = '0;
    check("t6_pre_valid", out_valid[6], 1);
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", out_valid, 0);
    check("t6_async_ready", in_ready, 0);
    tick;
    tick;
    rst_n = 1'b1;
    out_ready = '1;
    for (int j = 0; j < 5; j++) begin
      tick;
      check("t6_no_stale", out_valid, 0);
    end
    drive(0, 32'h77, D_WEST, 1'b1);
    tick;
    in_valid = '0;
    check("t6_new_valid", out_valid, 32'h100);
    check("t6_new_data", od(8), 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
